// File: rtl/tt_lut_pkg.sv
// Shared types and helpers for the reprogrammable truth-table gate.
package tt_lut_pkg;

  // Loader sequencing: wait for a start, shift in W bits, then commit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } ld_state_e;

  // Widest table supported (N_IN up to 6).
  localparam int unsigned MAX_W = 64;

  // Hex-name convention: MSB of the table is row 0, LSB is row W-1.
  function automatic logic row_sel(input logic [MAX_W-1:0] tbl,
                                   input int unsigned      w,
                                   input int unsigned      v);
    logic [5:0] idx;
    idx = 6'(w - 1 - v);
    return tbl[idx];
  endfunction

endpackage

// File: rtl/tt_cfg_loader.sv
// Serial truth-table loader: FSM, bit counter and shadow shift register.
// The shadow is only handed to the top level via a one-cycle commit strobe.
module tt_cfg_loader
  import tt_lut_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_ready,
  output logic                 commit,
  output logic [2**N_IN-1:0]   shadow
);

  localparam int W = 2**N_IN;
  // Counter value of the W-th (final) transfer; W-1 is all ones.
  localparam logic [N_IN-1:0] CNT_LAST = {N_IN{1'b1}};

  ld_state_e         state_q, state_d;
  logic [N_IN-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      shadow_q, shadow_d;

  assign shadow = shadow_q;

  // Next-state, shift and handshake outputs for the load sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    cfg_ready = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          shadow_d = {shadow_q[W-2:0], cfg_bit};
          if (cnt_q == CNT_LAST) begin
            state_d = COMMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Loader state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: rtl/tt_lut.sv
// Runtime-reprogrammable N_IN-input truth-table gate with registered output.
// The active table is replaced atomically when the loader commits, so a
// partially loaded table never reaches the evaluation path.
module tt_lut
  import tt_lut_pkg::*;
#(
  parameter int                 N_IN     = 3,
  parameter logic [2**N_IN-1:0] TT_RESET = 8'h85
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [N_IN-1:0]      in_data,
  output logic                 out_valid,
  output logic                 out,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_ready,
  output logic                 cfg_done,
  output logic [2**N_IN-1:0]   tt_active
);

  localparam int W = 2**N_IN;

  logic [W-1:0] shadow;
  logic         commit;

  logic [W-1:0] tt_active_q, tt_active_d;
  logic         out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic         cfg_done_q, cfg_done_d;

  tt_cfg_loader #(
    .N_IN (N_IN)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .commit    (commit),
    .shadow    (shadow)
  );

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign cfg_done  = cfg_done_q;
  assign tt_active = tt_active_q;

  // Evaluate against the table as it stands before this edge; commit swaps
  // the table in on the same edge, so a COMMIT-cycle request sees the old one.
  always_comb begin
    out_d       = out_q;
    out_valid_d = in_valid;
    tt_active_d = tt_active_q;
    cfg_done_d  = commit;
    if (in_valid) begin
      out_d = row_sel(MAX_W'(tt_active_q), W, 32'(in_data));
    end
    if (commit) begin
      tt_active_d = shadow;
    end
  end

  // Active table, evaluation result and done-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_active_q <= TT_RESET;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_done_q  <= 1'b0;
    end else begin
      tt_active_q <= tt_active_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

endmodule
